// File: rtl/thumb_imm_enc_if.sv
// Request/halfword bus of the Thumb immediate encoder. Signal suffixes give the
// direction as seen by the encoder (slave modport); the master modport is the requester/consumer.
interface thumb_imm_enc_if #(
  parameter int OP_W = 3
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [OP_W-1:0] req_op_i;
  logic [2:0]      req_rd_i;
  logic [2:0]      req_rn_i;
  logic [31:0]     req_imm_i;
  logic [31:0]     req_pc_i;
  logic            hw_valid_o;
  logic            hw_ready_i;
  logic [15:0]     hw_o;
  logic            hw_first_o;
  logic            err_o;

  modport master (
    output req_valid_i, req_op_i, req_rd_i, req_rn_i, req_imm_i, req_pc_i, hw_ready_i,
    input  req_ready_o, hw_valid_o, hw_o, hw_first_o, err_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_rd_i, req_rn_i, req_imm_i, req_pc_i, hw_ready_i,
    output req_ready_o, hw_valid_o, hw_o, hw_first_o, err_o
  );
endinterface

// File: rtl/thumb_imm_enc.sv
// Thumb immediate validator/encoder emitting a halfword stream (MOVS/ADDS/LSLS/LDR, BL as two halfwords).
// BL support (EMIT2 state, PC adder) is compiled in only when IMM_ENC_BL_EN is defined.
module thumb_imm_enc #(
  parameter int PC_OFFSET = 4,
  parameter int OP_W      = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  thumb_imm_enc_if.slave bus
);

  localparam logic [OP_W-1:0] OP_MOVS = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDS = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LSLS = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LDR  = OP_W'(3);
`ifdef IMM_ENC_BL_EN
  localparam logic [OP_W-1:0] OP_BL   = OP_W'(4);
`endif

`ifdef IMM_ENC_BL_EN
  typedef enum logic [1:0] {S_IDLE, S_EMIT1, S_EMIT2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EMIT1} state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_hw;
  logic [15:0] w_hw_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_ok;
  logic [15:0] w_hw1;
  logic [2:0]  w_rd;
  logic [2:0]  w_rn;
  logic [31:0] w_imm;

  assign w_rd  = bus.req_rd_i;
  assign w_rn  = bus.req_rn_i;
  assign w_imm = bus.req_imm_i;

`ifdef IMM_ENC_BL_EN
  logic               r_first;
  logic               w_first_nxt;
  logic [15:0]        r_hw2;
  logic [15:0]        w_hw2_nxt;
  logic               w_bl;
  logic [15:0]        w_hw2;
  logic signed [31:0] w_off;
  logic               w_s;
  logic               w_j1;
  logic               w_j2;
  logic               w_off_ok;

  // Offset is relative to the pipelined PC; 32-bit wrap-around is intended.
  assign w_off    = $signed(bus.req_imm_i - (bus.req_pc_i + 32'(PC_OFFSET)));
  assign w_s      = w_off[24];
  assign w_j1     = ~w_off[23] ^ w_s;
  assign w_j2     = ~w_off[22] ^ w_s;
  // Even, and representable as a 25-bit signed value.
  assign w_off_ok = ~w_off[0] && (w_off[31:25] == {7{w_off[24]}});
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.req_pc_i;
`endif

  // Validation and encoding of the presented request
  always_comb begin
    w_ok  = 1'b0;
    w_hw1 = '0;
`ifdef IMM_ENC_BL_EN
    w_bl  = 1'b0;
    w_hw2 = '0;
`endif
    case (bus.req_op_i)
      OP_MOVS: begin
        w_ok  = (w_imm[31:8] == '0);
        w_hw1 = {5'b00100, w_rd, w_imm[7:0]};
      end
      OP_ADDS: begin
        w_ok  = (w_imm[31:3] == '0);
        w_hw1 = {7'b0001110, w_imm[2:0], w_rn, w_rd};
      end
      OP_LSLS: begin
        w_ok  = (w_imm[31:5] == '0);
        w_hw1 = {5'b00000, w_imm[4:0], w_rn, w_rd};
      end
      OP_LDR: begin
        w_ok  = (w_imm[31:7] == '0) && (w_imm[1:0] == 2'b00);
        w_hw1 = {5'b01101, w_imm[6:2], w_rn, w_rd};
      end
`ifdef IMM_ENC_BL_EN
      OP_BL: begin
        w_ok  = w_off_ok;
        w_bl  = 1'b1;
        w_hw1 = {5'b11110, w_s, w_off[21:12]};
        w_hw2 = {2'b11, w_j1, 1'b1, w_j2, w_off[11:1]};
      end
`endif
      default: w_ok = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_hw_nxt    = r_hw;
    w_err_nxt   = 1'b0;
`ifdef IMM_ENC_BL_EN
    w_first_nxt = r_first;
    w_hw2_nxt   = r_hw2;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          if (w_ok) begin
            w_state_nxt = S_EMIT1;
            w_hw_nxt    = w_hw1;
`ifdef IMM_ENC_BL_EN
            w_first_nxt = w_bl;
            w_hw2_nxt   = w_hw2;
`endif
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_EMIT1: begin
        if (bus.hw_ready_i) begin
          w_state_nxt = S_IDLE;
`ifdef IMM_ENC_BL_EN
          if (r_first) begin
            w_state_nxt = S_EMIT2;
            w_hw_nxt    = r_hw2;
            w_first_nxt = 1'b0;
          end
`endif
        end
      end
`ifdef IMM_ENC_BL_EN
      S_EMIT2: begin
        if (bus.hw_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_hw    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hw    <= w_hw_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef IMM_ENC_BL_EN
  // Second BL halfword is captured at acceptance so later req_* changes cannot leak in.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_first <= 1'b0;
      r_hw2   <= '0;
    end else begin
      r_first <= w_first_nxt;
      r_hw2   <= w_hw2_nxt;
    end
  end

  assign bus.hw_first_o = r_first;
`else
  assign bus.hw_first_o = 1'b0;
`endif

  assign bus.req_ready_o = (r_state == S_IDLE);
  assign bus.hw_valid_o  = (r_state != S_IDLE);
  assign bus.hw_o        = r_hw;
  assign bus.err_o       = r_err;

endmodule

// File: tb/tb_thumb_imm_enc.sv
// Randomized bench for thumb_imm_enc against an arithmetic reference model.
// Follows IMM_ENC_BL_EN the same way the design does.
module tb_thumb_imm_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  thumb_imm_enc_if #(.OP_W(3)) bus ();

  thumb_imm_enc #(.PC_OFFSET(4), .OP_W(3)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: field values composed with plain arithmetic from the instruction set rules.
  function automatic void model(input int op, input int rd, input int rn,
                                input logic [31:0] imm, input logic [31:0] pc,
                                output bit ok, output int n,
                                output logic [15:0] h0, output logic [15:0] h1);
    logic [31:0] o32;
    longint      off;
    int          s, i1, i2, j1, j2;
    ok = 0; n = 0; h0 = '0; h1 = '0;
    o32 = '0; off = 0; s = 0; i1 = 0; i2 = 0; j1 = 0; j2 = 0;
    case (op)
      0: if (imm <= 255) begin
        ok = 1; n = 1; h0 = 16'(32'h2000 + rd * 256 + int'(imm));
      end
      1: if (imm <= 7) begin
        ok = 1; n = 1; h0 = 16'(32'h1C00 + int'(imm) * 64 + rn * 8 + rd);
      end
      2: if (imm <= 31) begin
        ok = 1; n = 1; h0 = 16'(int'(imm) * 64 + rn * 8 + rd);
      end
      3: if (imm <= 124 && (imm % 4) == 0) begin
        ok = 1; n = 1; h0 = 16'(32'h6800 + (int'(imm) / 4) * 64 + rn * 8 + rd);
      end
`ifdef IMM_ENC_BL_EN
      4: begin
        o32 = imm - pc - 32'd4;
        off = longint'($signed(o32));
        if ((o32 % 2) == 0 && off >= -(64'sd1 << 24) && off <= (64'sd1 << 24) - 2) begin
          s  = (off < 0) ? 1 : 0;
          i1 = int'((o32 >> 23) % 2);
          i2 = int'((o32 >> 22) % 2);
          j1 = (i1 == s) ? 1 : 0;
          j2 = (i2 == s) ? 1 : 0;
          ok = 1; n = 2;
          h0 = 16'(32'hF000 + s * 1024 + int'((o32 >> 12) % 1024));
          h1 = 16'(32'hD000 + j1 * 32'h2000 + j2 * 32'h800 + int'((o32 % 4096) / 2));
        end
      end
`endif
      default: ok = 0;
    endcase
  endfunction

  // Issue one request from IDLE (called at posedge+1) and follow it to completion.
  task automatic send(input int op, input int rd, input int rn,
                      input logic [31:0] imm, input logic [31:0] pc, input int stall);
    bit          ok;
    int          n;
    logic [15:0] h [2];
    model(op, rd, rn, imm, pc, ok, n, h[0], h[1]);
    check_eq("ready_idle", bus.req_ready_o, 1'b1);
    bus.req_op_i    = 3'(op);
    bus.req_rd_i    = 3'(rd);
    bus.req_rn_i    = 3'(rn);
    bus.req_imm_i   = imm;
    bus.req_pc_i    = pc;
    bus.req_valid_i = 1'b1;
    bus.hw_ready_i  = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (!ok) begin
      check_eq("err_pulse", bus.err_o, 1'b1);
      check_eq("err_no_valid", bus.hw_valid_o, 1'b0);
      @(posedge clk); #1;
      check_eq("err_clear", bus.err_o, 1'b0);
      check_eq("err_valid_low", bus.hw_valid_o, 1'b0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c <= stall; c++) begin
        check_eq("hw_valid", bus.hw_valid_o, 1'b1);
        check_eq("hw", bus.hw_o, h[i]);
        check_eq("first", bus.hw_first_o, (i == 0 && n == 2) ? 1'b1 : 1'b0);
        check_eq("no_err", bus.err_o, 1'b0);
        check_eq("busy_ready", bus.req_ready_o, 1'b0);
        if (c < stall) begin
          // Busy-time request noise must be ignored.
          bus.req_valid_i = 1'($urandom);
          bus.req_op_i    = 3'($urandom);
          bus.req_imm_i   = $urandom;
          bus.req_rd_i    = 3'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.req_valid_i = 1'b0;
      bus.hw_ready_i  = 1'b1;
      @(posedge clk); #1;
      bus.hw_ready_i  = 1'b0;
    end
    check_eq("done_valid", bus.hw_valid_o, 1'b0);
    check_eq("done_ready", bus.req_ready_o, 1'b1);
  endtask

  initial begin
    int          op, sel, stall;
    logic [31:0] imm, pc, off;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_rd_i    = '0;
    bus.req_rn_i    = '0;
    bus.req_imm_i   = '0;
    bus.req_pc_i    = '0;
    bus.hw_ready_i  = 1'b0;
    #3;
    check_eq("rst_valid", bus.hw_valid_o, 1'b0);
    check_eq("rst_hw", bus.hw_o, 16'h0);
    check_eq("rst_first", bus.hw_first_o, 1'b0);
    check_eq("rst_err", bus.err_o, 1'b0);
    check_eq("rst_ready", bus.req_ready_o, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 3, 0, 32'h5A, 32'h0, 0);
    send(1, 1, 2, 32'd7, 32'h0, 1);
    send(2, 0, 1, 32'd31, 32'h0, 0);
    send(1, 1, 2, 32'd8, 32'h0, 0);
    send(3, 4, 5, 32'd124, 32'h0, 2);
    send(3, 4, 5, 32'd6, 32'h0, 0);
    send(6, 1, 1, 32'd1, 32'h0, 0);
    send(0, 7, 0, 32'd256, 32'h0, 0);
    send(4, 0, 0, 32'h2000, 32'h1000, 3);
    send(4, 0, 0, 32'h1000, 32'h2000, 0);
    send(4, 0, 0, 32'h2001, 32'h1000, 0);
    send(4, 0, 0, 32'h1004 + 32'h0100_0000, 32'h1000, 0);
    send(4, 0, 0, 32'h1004 + 32'h00FF_FFFE, 32'h1000, 1);
    send(4, 0, 0, 32'h0100_2004 - 32'h0100_0000, 32'h0100_2000, 0);

    // Asynchronous reset mid-operation drops everything still pending.
`ifdef IMM_ENC_BL_EN
    bus.req_op_i = 3'd4; bus.req_imm_i = 32'h2000; bus.req_pc_i = 32'h1000;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check_eq("mid_first_hw", bus.hw_o, 16'hF000);
    bus.hw_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.hw_ready_i = 1'b0;
    check_eq("mid_second_hw", bus.hw_o, 16'hFFFE);
`else
    bus.req_op_i = 3'd0; bus.req_rd_i = 3'd3; bus.req_imm_i = 32'h5A;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check_eq("mid_hw", bus.hw_o, 16'h235A);
`endif
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", bus.hw_valid_o, 1'b0);
    check_eq("arst_hw", bus.hw_o, 16'h0);
    check_eq("arst_first", bus.hw_first_o, 1'b0);
    check_eq("arst_ready", bus.req_ready_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.hw_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("post_rst_valid", bus.hw_valid_o, 1'b0);
      check_eq("post_rst_ready", bus.req_ready_o, 1'b1);
    end
    bus.hw_ready_i = 1'b0;

    for (int k = 0; k < 200; k++) begin
      op    = int'($urandom_range(0, 7));
      sel   = int'($urandom_range(0, 3));
      stall = int'($urandom_range(0, 3));
      pc    = $urandom;
      case (sel)
        0:       imm = $urandom_range(0, 40);
        1:       imm = $urandom_range(0, 300);
        2:       imm = $urandom;
        default: imm = $urandom_range(120, 130);
      endcase
      if (op == 4) begin
        case ($urandom_range(0, 4))
          0:       off = 32'($urandom_range(0, 32'h1FFF_FFFF)) & 32'h01FF_FFFE;
          1:       off = 32'h00FF_FFFE;
          2:       off = 32'hFF00_0000;
          3:       off = 32'h0100_0000;
          default: off = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) off = ~off + 32'd1;
        imm = pc + 32'd4 + off;
      end
      send(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm, pc, stall);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
